// File: rtl/vr_hs_pkg.sv
// Shared types and constants for the valid/ready master source stage.
// Also provides the saturating counter helper used by the MASTER_HS_STATS_EN statistics.
package vr_hs_pkg;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_SEND = 1'b1
    } hs_state_t;

    localparam int HS_DATA_W = 8;
    localparam int HS_STAT_W = 16;

    function automatic logic [HS_STAT_W-1:0] sat_inc(input logic [HS_STAT_W-1:0] v);
        if (v == {HS_STAT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(HS_STAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/vr_sync_fifo.sv
// Small synchronous FIFO. Full and empty are derived from the occupancy count.
// The read data is the head entry and is presented combinationally.
module vr_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_s, pop_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign push_s    = push_i && !full_o;
    assign pop_s     = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Occupancy next-state: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/master_valid_ready_hs.sv
// Valid/ready source stage: FIFO-buffered producer bytes, one output register, sticky overflow.
// Optional handshake statistics (xfer_cnt, stall_cnt) when MASTER_HS_STATS_EN is defined.
module master_valid_ready_hs
    import vr_hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              ovf,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              s_ready,
`ifdef MASTER_HS_STATS_EN
    output logic [HS_STAT_W-1:0] xfer_cnt,
    output logic [HS_STAT_W-1:0] stall_cnt,
`endif
    output logic              idle
);

    hs_state_t         state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              ovf_q;
    logic              pop_s;
    logic [DATA_W-1:0] fifo_rd_s;
    logic              fifo_full_s, fifo_empty_s;

    vr_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk_i     (aclk),
        .rst_ni    (rstn),
        .push_i    (wr_en),
        .wr_data_i (wr_data),
        .pop_i     (pop_s),
        .rd_data_o (fifo_rd_s),
        .count_o   (fifo_count),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    // Output FSM: load the output register from the FIFO head when it is free or being consumed
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        pop_s    = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s    = 1'b1;
                    m_data_d = fifo_rd_s;
                    state_d  = HS_SEND;
                end else begin
                    state_d  = HS_IDLE;
                end
            end
            HS_SEND: begin
                if (!s_ready) begin
                    state_d = HS_SEND;
                end else if (!fifo_empty_s) begin
                    pop_s    = 1'b1;
                    m_data_d = fifo_rd_s;
                    state_d  = HS_SEND;
                end else begin
                    state_d = HS_IDLE;
                end
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase
    end

    // State, output register and sticky overflow
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= HS_IDLE;
            m_data_q <= {DATA_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            if (wr_en && fifo_full_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign m_valid = (state_q == HS_SEND);
    assign m_data  = m_data_q;
    assign ovf     = ovf_q;
    assign wr_full = fifo_full_s;
    assign idle    = fifo_empty_s && (state_q == HS_IDLE);

`ifdef MASTER_HS_STATS_EN
    logic [HS_STAT_W-1:0] xfer_cnt_q, stall_cnt_q;

    // Saturating handshake and stall counters
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            xfer_cnt_q  <= {HS_STAT_W{1'b0}};
            stall_cnt_q <= {HS_STAT_W{1'b0}};
        end else begin
            if (m_valid && s_ready) begin
                xfer_cnt_q <= sat_inc(xfer_cnt_q);
            end
            if (m_valid && !s_ready) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign xfer_cnt  = xfer_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_master_valid_ready_hs.sv
// Directed self-checking bench for master_valid_ready_hs (DEPTH=4).
// Statistics checks are compiled in only when MASTER_HS_STATS_EN is defined.
module tb_master_valid_ready_hs;

    logic       aclk;
    logic       rstn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_full;
    logic [2:0] fifo_count;
    logic       ovf;
    logic       m_valid;
    logic [7:0] m_data;
    logic       s_ready;
    logic       idle;
`ifdef MASTER_HS_STATS_EN
    logic [15:0] xfer_cnt;
    logic [15:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] rx_q[$];

    master_valid_ready_hs #(.DATA_W(8), .DEPTH(4)) dut (
        .aclk       (aclk),
        .rstn       (rstn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .fifo_count (fifo_count),
        .ovf        (ovf),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .s_ready    (s_ready),
`ifdef MASTER_HS_STATS_EN
        .xfer_cnt   (xfer_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .idle       (idle)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Slave-side receive monitor: record every completed handshake
    always @(posedge aclk) begin
        if (rstn && m_valid && s_ready) begin
            rx_q.push_back(m_data);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            @(negedge aclk);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        @(negedge aclk);
        rx_q.delete();
    endtask

    task automatic write_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            tick(1);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        s_ready = 1'b0;
        @(negedge aclk);
        check_val("rst_m_valid", 32'(m_valid), 32'd0);
        check_val("rst_m_data", 32'(m_data), 32'h00);
        check_val("rst_count", 32'(fifo_count), 32'd0);
        check_val("rst_wr_full", 32'(wr_full), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_idle", 32'(idle), 32'd1);
        rstn = 1'b1;
        tick(1);
        rx_q.delete();

        // single byte with s_ready high
        s_ready = 1'b1;
        write_bytes(8'hA5, 1);
        check_val("t1_e1_valid", 32'(m_valid), 32'd0);
        check_val("t1_e1_count", 32'(fifo_count), 32'd1);
        tick(1);
        check_val("t1_e2_valid", 32'(m_valid), 32'd1);
        check_val("t1_e2_data", 32'(m_data), 32'hA5);
        tick(1);
        check_val("t1_e3_valid", 32'(m_valid), 32'd0);
        check_val("t1_e3_idle", 32'(idle), 32'd1);
        check_val("t1_rx_n", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check_val("t1_rx0", 32'(rx_q[0]), 32'hA5);

        // burst of 5 against a stalled slave, then an overflowing 6th
        rx_q.delete();
        s_ready = 1'b0;
        write_bytes(8'h01, 5);
        check_val("t2_full", 32'(wr_full), 32'd1);
        check_val("t2_count", 32'(fifo_count), 32'd4);
        check_val("t2_ovf0", 32'(ovf), 32'd0);
        check_val("t2_out", 32'(m_data), 32'h01);
        write_bytes(8'h06, 1);
        check_val("t2_ovf1", 32'(ovf), 32'd1);
        check_val("t2_count6", 32'(fifo_count), 32'd4);
        s_ready = 1'b1;
        tick(5);
        check_val("t2_drained", 32'(m_valid), 32'd0);
        check_val("t2_rx_n", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check_val($sformatf("t2_rx%0d", i), 32'(rx_q[i]), 32'(i + 1));
        end
        check_val("t2_ovf_sticky", 32'(ovf), 32'd1);
        do_reset();
        check_val("t2_ovf_clr", 32'(ovf), 32'd0);

        // slave toggling ready every cycle
        s_ready = 1'b0;
        write_bytes(8'h10, 3);
        for (int i = 0; i < 8; i++) begin
            s_ready = (i % 2 == 1);
            if (rx_q.size() < 3) begin
                check_val($sformatf("t3_valid%0d", i), 32'(m_valid), 32'd1);
                check_val($sformatf("t3_data%0d", i), 32'(m_data), 32'(8'h10 + 8'(rx_q.size())));
            end
            tick(1);
        end
        s_ready = 1'b0;
        check_val("t3_rx_n", 32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            check_val($sformatf("t3_rx%0d", i), 32'(rx_q[i]), 32'(8'h10 + 8'(i)));
        end
        check_val("t3_idle", 32'(m_valid), 32'd0);

        // simultaneous push and pop with two entries queued
        rx_q.delete();
        write_bytes(8'h20, 3);
        check_val("t4_pre_count", 32'(fifo_count), 32'd2);
        s_ready = 1'b1;
        write_bytes(8'h23, 1);
        s_ready = 1'b0;
        check_val("t4_count", 32'(fifo_count), 32'd2);
        check_val("t4_data", 32'(m_data), 32'h21);
        s_ready = 1'b1;
        tick(3);
        s_ready = 1'b0;
        check_val("t4_rx_n", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() > 3) check_val("t4_rx3", 32'(rx_q[3]), 32'h23);
        check_val("t4_valid", 32'(m_valid), 32'd0);

        // asynchronous reset while a byte is held
        rx_q.delete();
        write_bytes(8'h30, 2);
        check_val("t5_pre_valid", 32'(m_valid), 32'd1);
        #1 rstn = 1'b0;
        #1;
        check_val("t5_async_valid", 32'(m_valid), 32'd0);
        check_val("t5_async_count", 32'(fifo_count), 32'd0);
        #1 rstn = 1'b1;
        @(negedge aclk);
        check_val("t5_idle", 32'(idle), 32'd1);
        s_ready = 1'b1;
        tick(3);
        check_val("t5_no_stale", 32'(rx_q.size()), 32'd0);
        check_val("t5_valid", 32'(m_valid), 32'd0);
        s_ready = 1'b0;

`ifdef MASTER_HS_STATS_EN
        do_reset();
        write_bytes(8'h40, 3);
        tick(3);
        s_ready = 1'b1;
        tick(3);
        s_ready = 1'b0;
        check_val("st_xfer", 32'(xfer_cnt), 32'd3);
        check_val("st_stall", 32'(stall_cnt), 32'd4);
        write_bytes(8'h50, 1);
        tick(65540);
        check_val("st_stall_sat", 32'(stall_cnt), 32'hFFFF);
        tick(2);
        check_val("st_stall_hold", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/master_valid_ready_hs.md
Name: master_valid_ready_hs

Overview:
- Upstream source stage for the 8-bit valid/ready slave receiver.
- Accepts bytes from a local producer into a small synchronous FIFO.
- Presents bytes one at a time on m_valid/m_data, holding each stable until the slave completes a handshake.
- Allows producer bursts to be absorbed while the slave throttles via s_ready.

Parameters:
- DATA_W, 8, payload width of wr_data and m_data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of fifo_count.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- wr_en  input  1  producer write strobe.
- wr_data  input  DATA_W  producer byte.
- wr_full  output  1  FIFO full; a write this cycle is dropped.
- fifo_count  output  CNT_W  occupied FIFO entries, excluding the output register.
- ovf  output  1  sticky overflow flag.
- m_valid  output  1  valid to slave.
- m_data  output  DATA_W  data to slave.
- s_ready  input  1  ready from slave.
- idle  output  1  high when FIFO is empty and m_valid=0.

Behaviour:
- Reset (rstn=0, asynchronous):
  - m_valid=0, m_data=0, fifo_count=0, wr_full=0, ovf=0, idle=1, state=IDLE.
  - FIFO pointers are cleared.
  - Reset mid-transfer discards the held byte and all FIFO contents. No handshake completes in the reset cycle.
- Handshake:
  - A transfer occurs at a rising edge where m_valid=1 and s_ready=1.
  - m_valid never depends combinationally on s_ready.
  - Once m_valid=1, m_valid and m_data stay constant until the transfer edge.
- Write:
  - On an edge with wr_en=1 and wr_full=0, wr_data is pushed.
  - wr_full is evaluated before the edge. A write while full is dropped, even if a pop occurs at the same edge, and sets ovf=1 until reset.
- FSM, two states:
  - IDLE (m_valid=0):
    - If FIFO non-empty at the edge: pop head into m_data, set m_valid=1, go to SEND.
    - Otherwise stay in IDLE.
  - SEND (m_valid=1):
    - If s_ready=0: hold.
    - If s_ready=1 and FIFO non-empty: pop next into m_data, keep m_valid=1, stay in SEND (back-to-back, one byte per cycle).
    - If s_ready=1 and FIFO empty: m_valid=0, go to IDLE. m_data keeps its last value.
- Latency:
  - Write accepted at edge k into an empty block: m_valid=1 after edge k+1. There is no write-to-output bypass.
- Simultaneous push and pop (FIFO not full): both occur and fifo_count is unchanged.
- Pointers: ADDR_W=$clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from fifo_count.
- Capacity: up to DEPTH+1 bytes in flight (DEPTH in the FIFO plus the output register).

Optional Feature:
- Macro: MASTER_HS_STATS_EN.
- Defined:
  - Adds output xfer_cnt[15:0], incremented on each completed handshake.
  - Adds output stall_cnt[15:0], incremented each cycle with m_valid=1 and s_ready=0.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists. Core behaviour is identical.

Decomposition:
- Package vr_hs_pkg:
  - State enum hs_state_t {HS_IDLE, HS_SEND}.
  - Constant HS_DATA_W=8.
  - Counter width constant HS_STAT_W=16.
- One natural sub-module: vr_sync_fifo.
  - Parameterised DATA_W/DEPTH.
  - Push/pop/count/full/empty.
- The top level holds the FSM, the output register, ovf and the optional stats.

Test Plan:
- Single byte, s_ready tied high:
  - Stimulus: write 8'hA5 at edge 1.
  - Response: m_valid=1 with m_data=8'hA5 after edge 2; transfer at edge 3; m_valid=0 and idle=1 after edge 3.
- Burst of 5 (8'h01..8'h05), DEPTH=4, s_ready=0:
  - Response: first byte moves to the output register; remaining 4 fill the FIFO; wr_full=1; ovf stays 0.
  - Then a 6th write is dropped and ovf=1.
  - Release s_ready: slave receives 01..05 in order on consecutive edges; 6th byte never appears.
- s_ready alternating 0/1 every cycle (slave toggling ready), 3 bytes 8'h10/11/12:
  - Response: m_data is stable while s_ready=0; all three received in order; no duplicates.
- Simultaneous push and pop with fifo_count=2 in SEND with s_ready=1:
  - Response: fifo_count stays 2; popped byte is presented next cycle.
- Reset mid-transfer: assert rstn=0 asynchronously while m_valid=1 and s_ready=0.
  - Response: m_valid=0 immediately (before the next edge); fifo_count=0; after release, idle=1 and no stale byte is sent.
- With MASTER_HS_STATS_EN:
  - Stimulus: 3 transfers with 4 stall cycles.
  - Response: xfer_cnt=3, stall_cnt=4.
  - Preload stall_cnt to saturation: it stays at 16'hFFFF.
